fifo_sync_param: RTL and testbench
==================================

# fifo_sync_param

Parametrised synchronous FIFO, the successor to the fixed 8-bit/256-entry buffer used between the Trivium keystream/data stages. It adds configurable width and depth, a true full condition at DEPTH entries, programmable almost-full/almost-empty thresholds, accepted read+write in the same cycle, synchronous flush, and sticky overflow/underflow error flags. It sits between producer and consumer stages in the same clock domain and keeps the registered-read plus `read_stb` output style.

## Interface
- `DATA_W`, default 8: data word width in bits.
- `ADDR_W`, default 4: pointer width. DEPTH = 2**ADDR_W entries.
- `AFULL_TH`, default 2**ADDR_W-2: `almost_full` asserts when count >= AFULL_TH. Legal range 1..DEPTH.
- `AEMPTY_TH`, default 2: `almost_empty` asserts when count <= AEMPTY_TH. Legal range 0..DEPTH-1.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `flush` in 1: synchronous clear of contents and error flags.
- `din` in DATA_W: write data.
- `write` in 1: write request.
- `read` in 1: read request.
- `dout` out DATA_W: registered read data.
- `read_stb` out 1: one-cycle pulse; `dout` holds newly read data.
- `count` out ADDR_W+1: current occupancy, 0..DEPTH.
- `empty`, `full` out 1: count==0 and count==DEPTH.
- `almost_empty`, `almost_full` out 1: threshold flags.
- `overflow`, `underflow` out 1: sticky error flags.

## Operation
- Storage: DEPTH x DATA_W array, not reset. Head (write) and tail (read) pointers are ADDR_W bits and wrap modulo DEPTH naturally.
- Priority per cycle: reset, then flush, then read/write.
- Reset (`rst`=0 at edge): head=tail=count=0; `dout`=0, `read_stb`=0, `overflow`=`underflow`=0. So `empty`=1, `almost_empty`=1, `full`=0, `almost_full`=0.
- Flush (`flush`=1): same as reset, except `dout` holds its value. Read/write in the same cycle are ignored, `read_stb`=0.
- Write acceptance: `write` && (!full || read_accepted). Store `din` at head; head+1.
- Read acceptance: `read` && !empty. `dout` <= mem[tail]; tail+1; `read_stb`=1 next cycle. Otherwise `read_stb`=0 and `dout` holds.
- Count: +1 on write only, -1 on read only, unchanged on both or neither.
- Full with read and write: both are accepted; the written slot is the one being freed; count stays DEPTH.
- Empty with read and write: the write is accepted, the read is rejected, and `underflow` sets. No read-through: the data is readable on the next cycle.
- A rejected write (full, no read) sets `overflow`. The data is dropped and pointers are unchanged.
- A rejected read (empty) sets `underflow`. `dout` holds and `read_stb`=0.
- Overflow/underflow stay set until reset or flush.
- Status flags are combinational decodes of the registered count.

## Timing
- Write latency: data written at edge N is readable with `read` asserted at edge N+1. `dout` is valid after edge N+1 with `read_stb`=1.
- Read latency: 1 cycle from accepted `read` to `dout`/`read_stb`.
- Flags and `count` reflect all operations accepted at the previous edge.
- Back-to-back reads every cycle give `read_stb` high continuously, with new `dout` each cycle.
- Reset or flush asserted mid-burst takes effect at that edge. The next cycle shows `empty`=1 and `read_stb`=0.

## Test plan
- Reset then idle -> `count`=0, `empty`=1, `almost_empty`=1, `full`=0, `dout`=0, `read_stb`=0, error flags 0.
- ADDR_W=4: write 0x01..0x10 (16 words), then 1 extra write 0xAA -> `full`=1 after the 16th, `almost_full`=1 from count 14, `overflow`=1. Read 16 -> `dout` 0x01..0x10 in order with `read_stb` each cycle; 0xAA never appears.
- Pointer wrap: repeatedly write 3 words and read 3, 20 times -> data order preserved across wrap; `count` returns to 0; no error flags.
- Simultaneous read+write at count=16 -> count stays 16, no overflow, new word emerges after 15 older words. At count=0 -> count becomes 1, `underflow`=1, `read_stb`=0.
- Read on empty -> `underflow`=1, `dout` unchanged, `read_stb`=0. Then `flush` -> `underflow`=0, `count`=0.
- Fill to 9 words, assert `flush` together with `write` and `read` -> `count`=0, `empty`=1, `read_stb`=0 next cycle; the following write/read returns only post-flush data.

Source files
------------

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised synchronous FIFO with thresholds, flush and sticky error flags
module fifo_sync_param #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int AFULL_TH  = 2**ADDR_W-2,
  parameter int AEMPTY_TH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  input  logic              write,
  input  logic              read,
  output logic [DATA_W-1:0] dout,
  output logic              read_stb,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic              overflow,
  output logic              underflow
);
  localparam int CW    = ADDR_W+1;
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] head, tail;
  logic              rd_ok, wr_ok;
  assign empty        = count == '0;
  assign full         = count == CW'(DEPTH);
  assign almost_empty = count <= CW'(AEMPTY_TH);
  assign almost_full  = count >= CW'(AFULL_TH);
  assign rd_ok        = read && !empty;
  assign wr_ok        = write && (!full || rd_ok);
  // storage is not reset; a write into a full FIFO with a read reuses the slot being freed
  always_ff @(posedge clk)
    if (rst && !flush && wr_ok) mem[head] <= din;
  // pointers, occupancy, registered read data and sticky error flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      dout      <= '0;
      read_stb  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      read_stb  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) head <= head + 1'b1;
      if (rd_ok) begin
        tail <= tail + 1'b1;
        dout <= mem[tail];
      end
      read_stb <= rd_ok;
      count    <= count + CW'(wr_ok) - CW'(rd_ok);
      if (write && !wr_ok) overflow <= 1'b1;
      if (read && !rd_ok) underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: vector table, directed corner sequences and queue-model random test
module tb_fifo_sync_param;
  logic       clk = 1'b0;
  logic       rst, flush, write, read;
  logic [7:0] din, dout;
  logic       read_stb, empty, full, almost_empty, almost_full, overflow, underflow;
  logic [4:0] count;
  int         passed = 0, total = 0;

  fifo_sync_param dut (
    .clk(clk), .rst(rst), .flush(flush), .din(din), .write(write), .read(read),
    .dout(dout), .read_stb(read_stb), .count(count), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r, f, w, rd;
    logic [7:0] d;
    logic [4:0] cnt;
    logic       rs;
    logic [7:0] q;
    logic       ov, un;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic step(input logic r, input logic f, input logic w, input logic rd, input logic [7:0] d);
    rst = r; flush = f; write = w; read = rd; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int cnt, input logic rs, input logic [7:0] q,
                         input logic ov, input logic un);
    chk({tag, ".count"}, count, cnt);
    chk({tag, ".empty"}, empty, cnt == 0);
    chk({tag, ".full"}, full, cnt == 16);
    chk({tag, ".aempty"}, almost_empty, cnt <= 2);
    chk({tag, ".afull"}, almost_full, cnt >= 14);
    chk({tag, ".read_stb"}, read_stb, rs);
    chk({tag, ".dout"}, dout, q);
    chk({tag, ".overflow"}, overflow, ov);
    chk({tag, ".underflow"}, underflow, un);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] m_dout;
    logic       m_rs, m_ov, m_un, rd_ok, wr_ok, r, f, w, rd;
    logic [7:0] d;
    rst = 1'b0; flush = 1'b0; write = 1'b0; read = 1'b0; din = '0;

    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h11, 5'd1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h22, 5'd2, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 5'd1, 1'b1, 8'h11, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 5'd1, 1'b1, 8'h22, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 8'h33, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h44, 5'd1, 1'b0, 8'h33, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 8'h33, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 8'h44, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0};
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].r, tbl[i].f, tbl[i].w, tbl[i].rd, tbl[i].d);
      chk_all($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].rs, tbl[i].q, tbl[i].ov, tbl[i].un);
    end

    // fill to full, overflow, drain in order
    step(0, 0, 0, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      step(1, 0, 1, 0, 8'(k));
      chk_all($sformatf("fill%0d", k), k, 1'b0, 8'h00, 1'b0, 1'b0);
    end
    step(1, 0, 1, 0, 8'hAA);
    chk_all("ovf", 16, 1'b0, 8'h00, 1'b1, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      step(1, 0, 0, 1, 0);
      chk_all($sformatf("drain%0d", k), 16 - k, 1'b1, 8'(k), 1'b1, 1'b0);
    end
    step(1, 0, 0, 0, 0);
    chk_all("drained", 0, 1'b0, 8'h10, 1'b1, 1'b0);

    // pointer wrap
    step(0, 0, 0, 0, 0);
    for (int it = 0; it < 20; it++) begin
      for (int j = 0; j < 3; j++) step(1, 0, 1, 0, 8'(it * 3 + j + 1));
      for (int j = 0; j < 3; j++) begin
        step(1, 0, 0, 1, 0);
        chk($sformatf("wrap%0d.%0d", it, j), dout, 8'(it * 3 + j + 1));
        chk("wrap.stb", read_stb, 1'b1);
      end
    end
    chk_all("wrap_end", 0, 1'b1, 8'd60, 1'b0, 1'b0);

    // simultaneous read+write when full
    step(0, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) step(1, 0, 1, 0, 8'(8'h40 + k));
    step(1, 0, 1, 1, 8'hEE);
    chk_all("rw_full", 16, 1'b1, 8'h40, 1'b0, 1'b0);
    for (int k = 1; k < 16; k++) begin
      step(1, 0, 0, 1, 0);
      chk($sformatf("rw_old%0d", k), dout, 8'(8'h40 + k));
    end
    step(1, 0, 0, 1, 0);
    chk_all("rw_new", 0, 1'b1, 8'hEE, 1'b0, 1'b0);

    // flush mid-stream with write and read
    step(0, 0, 0, 0, 0);
    for (int k = 0; k < 9; k++) step(1, 0, 1, 0, 8'(8'h90 + k));
    step(1, 0, 1, 0, 8'hBB);
    step(1, 0, 0, 1, 0);
    chk("pre_flush", dout, 8'h90);
    step(1, 1, 1, 1, 8'hCC);
    chk_all("flush", 0, 1'b0, 8'h90, 1'b0, 1'b0);
    step(1, 0, 1, 0, 8'h77);
    step(1, 0, 0, 1, 0);
    chk_all("post_flush", 0, 1'b1, 8'h77, 1'b0, 1'b0);

    // randomized run against a queue model
    step(0, 0, 0, 0, 0);
    q.delete(); m_dout = 0; m_rs = 0; m_ov = 0; m_un = 0;
    for (int i = 0; i < 3000; i++) begin
      r  = $urandom_range(199) != 0;
      f  = $urandom_range(99) < 2;
      w  = ((i / 200) % 2) ? $urandom_range(99) < 75 : $urandom_range(99) < 40;
      rd = ((i / 200) % 2) ? $urandom_range(99) < 40 : $urandom_range(99) < 75;
      d  = 8'($urandom);
      step(r, f, w, rd, d);
      if (!r) begin
        q.delete(); m_dout = 0; m_rs = 0; m_ov = 0; m_un = 0;
      end else if (f) begin
        q.delete(); m_rs = 0; m_ov = 0; m_un = 0;
      end else begin
        rd_ok = rd && q.size() > 0;
        wr_ok = w && (q.size() < 16 || rd_ok);
        m_rs = rd_ok;
        if (rd_ok) m_dout = q.pop_front();
        if (wr_ok) q.push_back(d);
        if (w && !wr_ok) m_ov = 1;
        if (rd && !rd_ok) m_un = 1;
      end
      chk_all($sformatf("rnd%0d", i), q.size(), m_rs, m_dout, m_ov, m_un);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
